// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-side definitions: pipeline hold levels, bus widths, reset
// address, NOP encoding, fetch FSM states and the fetch-buffer entry layout.
package ifetch_unit_pkg;

  localparam int unsigned HoldFlagW = 3;
  localparam int unsigned InstW     = 32;
  localparam int unsigned InstAddrW = 32;

  localparam logic [HoldFlagW-1:0] HoldNone = 3'd0;
  localparam logic [HoldFlagW-1:0] HoldPc   = 3'd1;
  localparam logic [HoldFlagW-1:0] HoldIf   = 3'd2;
  localparam logic [HoldFlagW-1:0] HoldId   = 3'd3;

  localparam logic [31:0]        ZeroWord     = 32'h0000_0000;
  localparam logic [31:0]        CpuResetAddr = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [InstW-1:0]   InstNop      = 32'h0000_0013;

  typedef enum logic [0:0] {
    StIdle,  // no bus transaction outstanding
    StWait   // granted, response not yet returned
  } fetch_state_e;

  typedef struct packed {
    logic [InstAddrW-1:0] addr;
    logic [InstW-1:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Fetch buffer: small power-of-two FIFO of {address, instruction} entries.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i, data_i  write an entry (accepted when not full, or full with pop_i)
//   pop_i           drop the head entry (ignored when empty)
//   flush_i         empty the buffer; overrides push/pop
//   data_o          head entry
//   full_o, empty_o, count_o  occupancy
module ifetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CntW'(DEPTH));
    empty_o = (count_q == '0);
    count_o = count_q;
    data_o  = mem_q[rd_ptr_q];
    do_push = push_i && (!full_o || pop_i);
    do_pop  = pop_i && !empty_o;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset; only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues word fetches on a req/gnt/rvalid bus with
// at most one transaction in flight, buffers responses and presents them
// to if_id. A jump flushes the buffer, redirects the PC and kills any
// in-flight fetch so its late response is dropped.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   jump_flag_i, jump_addr_i       redirect from execute
//   hold_flag_i                    pipeline hold level (>= HoldIf freezes head)
//   ibus_req_o, ibus_addr_o        fetch request and word address
//   ibus_gnt_i                     request accepted this cycle
//   ibus_rvalid_i, ibus_rdata_i    response
//   inst_o, inst_addr_o, inst_valid_o  buffered instruction to if_id
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = CpuResetAddr,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_flag_i,
  input  logic [31:0]           jump_addr_i,
  input  logic [HoldFlagW-1:0]  hold_flag_i,
  output logic                  ibus_req_o,
  output logic [31:0]           ibus_addr_o,
  input  logic                  ibus_gnt_i,
  input  logic                  ibus_rvalid_i,
  input  logic [31:0]           ibus_rdata_i,
  output logic [InstW-1:0]      inst_o,
  output logic [InstAddrW-1:0]  inst_addr_o,
  output logic                  inst_valid_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [31:2]     pc_q, pc_d;
  logic [31:0]     pend_addr_q, pend_addr_d;
  logic            kill_q, kill_d;

  logic            hold_en, outstanding, grant, push, pop;
  logic [CntW-1:0] fifo_count, occupied;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    push_entry, head_entry;
  logic            unused_sig;

  assign unused_sig = ^{jump_addr_i[1:0], fifo_full};

  always_comb begin
    hold_en     = (hold_flag_i >= HoldIf);
    outstanding = (state_q == StWait);
    // A killed fetch will never land in the buffer, so it reserves no slot.
    occupied    = fifo_count + CntW'(outstanding && !kill_q);
    ibus_addr_o = {pc_q, 2'b00};
    ibus_req_o  = !rst && (!outstanding || ibus_rvalid_i) && (occupied < CntW'(FIFO_DEPTH));
    grant       = ibus_req_o && ibus_gnt_i;

    push             = outstanding && ibus_rvalid_i && !kill_q && !jump_flag_i;
    push_entry.addr  = pend_addr_q;
    push_entry.inst  = ibus_rdata_i;

    inst_valid_o = !rst && !fifo_empty;
    pop          = inst_valid_o && !hold_en && !jump_flag_i;
    inst_o       = inst_valid_o ? head_entry.inst : InstNop;
    inst_addr_o  = inst_valid_o ? head_entry.addr : ZeroWord;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    kill_d      = kill_q;

    unique case (state_q)
      StIdle: if (grant) state_d = StWait;
      StWait: if (ibus_rvalid_i) state_d = grant ? StWait : StIdle;
      default: state_d = StIdle;
    endcase

    if (grant) begin
      pc_d        = pc_q + 30'd1;  // wraps 0xFFFF_FFFC -> 0x0
      pend_addr_d = ibus_addr_o;
    end

    // Any response retires the old kill; a jump kills whatever stays in flight.
    if (outstanding && ibus_rvalid_i) kill_d = 1'b0;
    if (jump_flag_i) begin
      pc_d   = jump_addr_i[31:2];
      kill_d = (state_d == StWait);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC[31:2];
      pend_addr_q <= ZeroWord;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      kill_q      <= kill_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (jump_flag_i),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit. Inputs change only at the falling edge;
// a one-cycle memory responder answers every grant with rdata = addr + 0x13.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  // Values applied at the next falling edge.
  logic        rst_v, jump_v, gnt_en, force_rv;
  logic [31:0] jaddr_v;
  logic [2:0]  hold_v;
  // Grant captured in the current cycle, answered in the next.
  logic        pend_g;
  logic [31:0] pend_a;

  int errors = 0;
  int checks = 0;

  ifetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Close the current cycle at the rising edge, then open the next one.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    rst           = rst_v;
    hold_flag_i   = hold_v;
    jump_flag_i   = jump_v;
    jump_addr_i   = jaddr_v;
    ibus_gnt_i    = gnt_en;
    ibus_rvalid_i = pend_g || force_rv;
    ibus_rdata_i  = pend_a + 32'h13;
    #1;
    pend_g = ibus_req_o && ibus_gnt_i;
    pend_a = ibus_addr_o;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One reset cycle; the caller then sets up and calls cyc() into cycle A.
  task automatic reset_cycle();
    rst_v = 1'b1; hold_v = 3'd0; jump_v = 1'b0; jaddr_v = '0;
    gnt_en = 1'b1; force_rv = 1'b0;
    cyc();
    rst_v = 1'b0;
  endtask

  initial begin
    rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = '0; hold_flag_i = '0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
    pend_g = 1'b0; pend_a = '0;

    // Reset state
    reset_cycle();
    chk("rst_req",   {31'd0, ibus_req_o},   32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst",  inst_o,                32'h0000_0013);
    chk("rst_iaddr", inst_addr_o,           32'h0);

    // First fetch latency, then hold for 6 cycles
    hold_v = 3'd2;
    cyc();  // A
    chk("first_req",  {31'd0, ibus_req_o}, 32'd1);
    chk("first_addr", ibus_addr_o,         32'h0);
    cyc();  // A+1
    chk("lat_valid_early", {31'd0, inst_valid_o}, 32'd0);
    cyc();  // A+2
    chk("lat_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("lat_inst",  inst_o,                32'h0000_0013);
    chk("lat_iaddr", inst_addr_o,           32'h0);
    chk("hold_req_a2", {31'd0, ibus_req_o}, 32'd0);
    cyc();  // A+3
    chk("hold_req_a3", {31'd0, ibus_req_o}, 32'd0);
    cyc(); cyc();  // A+5
    chk("hold_head", inst_addr_o,          32'h0);
    chk("hold_req_a5", {31'd0, ibus_req_o}, 32'd0);
    hold_v = 3'd0;
    cyc();  // A+6
    chk("rel_head0", inst_addr_o,          32'h0);
    chk("rel_req",   {31'd0, ibus_req_o}, 32'd0);
    cyc();  // A+7
    chk("rel_head4",  inst_addr_o,          32'h4);
    chk("rel_inst4",  inst_o,               32'h0000_0017);
    chk("rel_req2",   {31'd0, ibus_req_o}, 32'd1);
    chk("rel_addr8",  ibus_addr_o,          32'h8);
    cyc();  // A+8
    chk("rel_gap", {31'd0, inst_valid_o}, 32'd0);
    cyc();  // A+9
    chk("rel_head8", inst_addr_o, 32'h8);
    chk("rel_inst8", inst_o,      32'h0000_001B);

    // Jump in the same cycle as the grant for 0x8
    reset_cycle();
    cyc();  // A
    cyc();  // A+1
    cyc();  // A+2
    chk("jmp_req_a2", {31'd0, ibus_req_o}, 32'd0);
    jump_v = 1'b1; jaddr_v = 32'h0000_0102;
    cyc();  // A+3
    chk("jmp_head",  inst_addr_o,          32'h4);
    chk("jmp_addr8", ibus_addr_o,          32'h8);
    chk("jmp_req8",  {31'd0, ibus_req_o}, 32'd1);
    jump_v = 1'b0;
    cyc();  // A+4: killed response for 0x8 arrives
    chk("jmp_flushed", {31'd0, inst_valid_o}, 32'd0);
    chk("jmp_req100",  {31'd0, ibus_req_o},   32'd1);
    chk("jmp_addr100", ibus_addr_o,           32'h100);
    cyc();  // A+5
    chk("jmp_killed", {31'd0, inst_valid_o}, 32'd0);
    cyc();  // A+6
    chk("jmp_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("jmp_iaddr", inst_addr_o,           32'h100);
    chk("jmp_inst",  inst_o,                32'h0000_0113);

    // PC wrap at the top of the address space
    reset_cycle();
    jump_v = 1'b1; jaddr_v = 32'hFFFF_FFFC;
    cyc();  // A
    jump_v = 1'b0;
    cyc();  // A+1
    chk("wrap_top", ibus_addr_o, 32'hFFFF_FFFC);
    cyc();  // A+2
    chk("wrap_zero",  ibus_addr_o,           32'h0);
    chk("wrap_empty", {31'd0, inst_valid_o}, 32'd0);
    cyc();  // A+3
    chk("wrap_iaddr", inst_addr_o, 32'hFFFF_FFFC);
    chk("wrap_inst",  inst_o,      32'h0000_000F);

    // Grant withheld for 3 cycles
    reset_cycle();
    cyc();  // A: grant 0x0
    gnt_en = 1'b0;
    cyc();  // A+1
    chk("gdly_addr1", ibus_addr_o,          32'h4);
    chk("gdly_req1",  {31'd0, ibus_req_o}, 32'd1);
    cyc();  // A+2
    chk("gdly_addr2", ibus_addr_o, 32'h4);
    chk("gdly_head",  inst_addr_o, 32'h0);
    cyc();  // A+3
    chk("gdly_addr3", ibus_addr_o,          32'h4);
    chk("gdly_req3",  {31'd0, ibus_req_o}, 32'd1);
    gnt_en = 1'b1;
    cyc();  // A+4
    chk("gdly_addr4", ibus_addr_o, 32'h4);
    cyc();  // A+5
    chk("gdly_addr8", ibus_addr_o, 32'h8);

    // Reset while a fetch is outstanding; stray responses are ignored
    rst_v = 1'b1;
    cyc();  // response for 0x4... 0x8 arrives during reset
    chk("mrst_req",   {31'd0, ibus_req_o},   32'd0);
    chk("mrst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("mrst_inst",  inst_o,                32'h0000_0013);
    rst_v = 1'b0; force_rv = 1'b1;
    cyc();  // B: stray rvalid with nothing outstanding
    chk("mrst_req0",   {31'd0, ibus_req_o},   32'd1);
    chk("mrst_addr0",  ibus_addr_o,           32'h0);
    chk("mrst_valid0", {31'd0, inst_valid_o}, 32'd0);
    force_rv = 1'b0;
    cyc();  // B+1
    chk("mrst_nopush", {31'd0, inst_valid_o}, 32'd0);
    cyc();  // B+2
    chk("mrst_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("mrst_iaddr", inst_addr_o,           32'h0);
    chk("mrst_inst0", inst_o,                32'h0000_0013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
